// File: rtl/fdd_track_emu.sv
// ---------------------------------------------------------------------------
// fdd_track_emu
//
// Floppy drive emulator placed directly behind the FDC drive interface. It
// spins a pre-MFM-encoded track image held in an external track RAM, turns
// the stored bitcells into RDATA pulses, generates INDEX, tracks the head
// cylinder from STEP/DIR, and captures write-gate bitcells back into the RAM.
//
// Ports
//   iCLK, iRESET        16 MHz FDC clock, synchronous active-high reset
//   iMOTOR, iIMG_READY  rotation runs only while both are high
//   iSTEP, iDIR         step strobe (async, rising edge) and direction (1 = in)
//   iSIDE1              head select
//   iWG, iWDATA         write gate and asynchronous write pulses
//   iIMG_WP             image write protect (blocks RAM writes, not capture)
//   iRAM_DATA           track RAM read data, one clock after oRAM_ADDR
//   oRAM_ADDR/WDATA/WE  track RAM address, captured byte, write strobe
//   oRDATA, oINDEX      read pulses and index window to the controller
//   oTR00, oWPRT        track-0 and write-protect status
//   oTRACK, oSIDE       current cylinder and registered side
//   oTRK_CHG            one-clock pulse when cylinder or side changes
//   oDIRTY, iDIRTY_CLR  sticky "image modified" flag and its clear
// ---------------------------------------------------------------------------
module fdd_track_emu #(
    parameter int CELL_CLKS   = 32,
    parameter int TRACK_BYTES = 12500,
    parameter int INDEX_BYTES = 250,
    parameter int PULSE_CLKS  = 4,
    parameter int MAX_TRACK   = 83
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iMOTOR,
    input  logic        iSTEP,
    input  logic        iDIR,
    input  logic        iSIDE1,
    input  logic        iWG,
    input  logic        iWDATA,
    input  logic        iIMG_READY,
    input  logic        iIMG_WP,
    input  logic [7:0]  iRAM_DATA,
    output logic [13:0] oRAM_ADDR,
    output logic [7:0]  oRAM_WDATA,
    output logic        oRAM_WE,
    output logic        oRDATA,
    output logic        oINDEX,
    output logic        oTR00,
    output logic        oWPRT,
    output logic [6:0]  oTRACK,
    output logic        oSIDE,
    output logic        oTRK_CHG,
    output logic        oDIRTY,
    input  logic        iDIRTY_CLR
);

    localparam int              CW        = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1;
    localparam logic [CW-1:0]   CELL_LAST = CW'(CELL_CLKS - 1);
    localparam logic [CW:0]     PULSE_END = (CW + 1)'(PULSE_CLKS);
    localparam logic [13:0]     POS_LAST  = 14'(TRACK_BYTES - 1);
    localparam logic [13:0]     IDX_END   = 14'(INDEX_BYTES);
    localparam logic [6:0]      TRK_MAX   = 7'(MAX_TRACK);

    // -----------------------------------------------------------------------
    // Rotation: cell clock counter, cell within byte, byte position on track
    // -----------------------------------------------------------------------
    logic [CW-1:0] cellCnt;
    logic [2:0]    cellIdx;
    logic [13:0]   pos;
    logic [7:0]    shift;
    logic          spinning;
    logic          cellEnd;
    logic          byteEnd;
    logic          byteStart;
    logic [13:0]   posNext;

    assign spinning  = iMOTOR & iIMG_READY;
    assign cellEnd   = (cellCnt == CELL_LAST);
    assign byteEnd   = cellEnd && (cellIdx == 3'd7);
    assign byteStart = (cellCnt == '0) && (cellIdx == 3'd0);
    assign posNext   = (pos == POS_LAST) ? 14'd0 : pos + 14'd1;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            cellCnt <= '0;
            cellIdx <= 3'd0;
            pos     <= 14'd0;
            shift   <= 8'd0;
        end else if (spinning) begin
            if (cellEnd) begin
                cellCnt <= '0;
                cellIdx <= cellIdx + 3'd1;
                if (cellIdx == 3'd7)
                    pos <= posNext;
            end else begin
                cellCnt <= cellCnt + 1'b1;
            end
            // The address for the next byte has been on the bus all byte,
            // so the RAM word is valid on the last clock.
            if (byteEnd)
                shift <= iRAM_DATA;
        end
    end

    // -----------------------------------------------------------------------
    // Read pulses: MSB-first cell bit, pulse window at the head of the cell.
    // ~cellIdx selects bit 7 for cell 0 down to bit 0 for cell 7.
    // -----------------------------------------------------------------------
    logic pulseWin;
    assign pulseWin = ({1'b0, cellCnt} < PULSE_END);
    assign oRDATA   = spinning & ~iWG & shift[~cellIdx] & pulseWin;

    always_ff @(posedge iCLK) begin
        if (iRESET)
            oINDEX <= 1'b0;
        else
            oINDEX <= spinning && (pos < IDX_END);
    end

    // -----------------------------------------------------------------------
    // Head positioning and side select
    // stepPipe[1:0] is the synchroniser, stepPipe[2] the edge-detect history.
    // -----------------------------------------------------------------------
    logic [2:0] stepPipe;
    logic [1:0] sideSync;
    logic       stepRise;
    logic       sideChg;
    logic [6:0] trackNext;

    assign stepRise = stepPipe[1] & ~stepPipe[2];
    assign sideChg  = sideSync[1] ^ oSIDE;

    always_comb begin
        trackNext = oTRACK;
        if (stepRise) begin
            if (iDIR) begin
                if (oTRACK < TRK_MAX)
                    trackNext = oTRACK + 7'd1;
            end else if (oTRACK != 7'd0) begin
                trackNext = oTRACK - 7'd1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            stepPipe <= 3'b000;
            sideSync <= 2'b00;
            oTRACK   <= 7'd0;
            oTR00    <= 1'b1;
            oSIDE    <= 1'b0;
            oTRK_CHG <= 1'b0;
            oWPRT    <= 1'b0;
        end else begin
            stepPipe <= {stepPipe[1:0], iSTEP};
            sideSync <= {sideSync[0], iSIDE1};
            oTRACK   <= trackNext;
            oTR00    <= (trackNext == 7'd0);
            oSIDE    <= sideSync[1];
            // Saturated steps leave trackNext unchanged, so they never pulse;
            // a coincident step and side change merge into one pulse.
            oTRK_CHG <= (trackNext != oTRACK) | sideChg;
            oWPRT    <= iIMG_WP;
        end
    end

    // -----------------------------------------------------------------------
    // Write capture
    // capValid is armed only at byte clock 0 with the gate already open and
    // drops whenever the gate closes, so a byte is committed only if the gate
    // covered all eight cells.
    // -----------------------------------------------------------------------
    logic [2:0]  wdPipe;
    logic        wEdge;
    logic        capturing;
    logic        cellHit;
    logic        cellBit;
    logic [6:0]  capByte;
    logic        capValid;
    logic        weReg;
    logic [13:0] wAddr;

    assign wEdge     = wdPipe[1] & ~wdPipe[2];
    assign capturing = spinning & iWG;
    assign cellBit   = cellHit | wEdge;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            wdPipe     <= 3'b000;
            cellHit    <= 1'b0;
            capByte    <= 7'd0;
            capValid   <= 1'b0;
            weReg      <= 1'b0;
            wAddr      <= 14'd0;
            oRAM_WDATA <= 8'd0;
            oDIRTY     <= 1'b0;
        end else begin
            wdPipe <= {wdPipe[1:0], iWDATA};
            weReg  <= 1'b0;
            if (!capturing) begin
                cellHit  <= 1'b0;
                capByte  <= 7'd0;
                capValid <= 1'b0;
            end else begin
                if (byteStart)
                    capValid <= 1'b1;
                if (cellEnd) begin
                    cellHit <= 1'b0;
                    capByte <= {capByte[5:0], cellBit};
                end else if (wEdge) begin
                    cellHit <= 1'b1;
                end
                // Commit on the final clock; the strobe shows on clock 0 of
                // the following byte, addressed to the byte just finished.
                if (byteEnd && capValid && !iIMG_WP) begin
                    weReg      <= 1'b1;
                    wAddr      <= pos;
                    oRAM_WDATA <= {capByte, cellBit};
                end
            end
            if (weReg)
                oDIRTY <= 1'b1;
            else if (iDIRTY_CLR)
                oDIRTY <= 1'b0;
        end
    end

    assign oRAM_WE   = weReg;
    assign oRAM_ADDR = weReg ? wAddr : posNext;

endmodule

// File: tb/tb_fdd_track_emu.sv
// ---------------------------------------------------------------------------
// tb_fdd_track_emu
//
// Directed bench for fdd_track_emu using a 16-byte track so a revolution is
// 4096 clocks. A small track RAM model answers reads one clock after the
// address and accepts the emulator's writes. cyc counts clocks from the
// first spinning clock, so byte position = cyc/256 mod 16 while spinning.
// ---------------------------------------------------------------------------
module tb_fdd_track_emu;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic        iMOTOR;
    logic        iSTEP;
    logic        iDIR;
    logic        iSIDE1;
    logic        iWG;
    logic        iWDATA;
    logic        iIMG_READY;
    logic        iIMG_WP;
    logic [7:0]  iRAM_DATA;
    logic [13:0] oRAM_ADDR;
    logic [7:0]  oRAM_WDATA;
    logic        oRAM_WE;
    logic        oRDATA;
    logic        oINDEX;
    logic        oTR00;
    logic        oWPRT;
    logic [6:0]  oTRACK;
    logic        oSIDE;
    logic        oTRK_CHG;
    logic        oDIRTY;
    logic        iDIRTY_CLR;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;
    int chgCnt = 0;
    int weCnt  = 0;

    logic [7:0] ram [0:15];

    fdd_track_emu #(
        .CELL_CLKS  (32),
        .TRACK_BYTES(16),
        .INDEX_BYTES(2),
        .PULSE_CLKS (4),
        .MAX_TRACK  (83)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iMOTOR     (iMOTOR),
        .iSTEP      (iSTEP),
        .iDIR       (iDIR),
        .iSIDE1     (iSIDE1),
        .iWG        (iWG),
        .iWDATA     (iWDATA),
        .iIMG_READY (iIMG_READY),
        .iIMG_WP    (iIMG_WP),
        .iRAM_DATA  (iRAM_DATA),
        .oRAM_ADDR  (oRAM_ADDR),
        .oRAM_WDATA (oRAM_WDATA),
        .oRAM_WE    (oRAM_WE),
        .oRDATA     (oRDATA),
        .oINDEX     (oINDEX),
        .oTR00      (oTR00),
        .oWPRT      (oWPRT),
        .oTRACK     (oTRACK),
        .oSIDE      (oSIDE),
        .oTRK_CHG   (oTRK_CHG),
        .oDIRTY     (oDIRTY),
        .iDIRTY_CLR (iDIRTY_CLR)
    );

    always #5 iCLK = ~iCLK;

    // Track RAM: image loaded on reset (byte1=A0, byte5=FF, rest 0)
    always @(posedge iCLK) begin
        if (iRESET) begin
            for (int i = 0; i < 16; i++)
                ram[i] <= (i == 1) ? 8'hA0 : ((i == 5) ? 8'hFF : 8'h00);
        end else if (oRAM_WE) begin
            ram[oRAM_ADDR[3:0]] <= oRAM_WDATA;
        end
        iRAM_DATA <= ram[oRAM_ADDR[3:0]];
    end

    always @(negedge iCLK) begin
        if (oTRK_CHG) chgCnt <= chgCnt + 1;
        if (oRAM_WE)  weCnt  <= weCnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
            cyc++;
        end
    endtask

    task automatic gotoByte(input int p);
        while (!(((cyc / 256) % 16) == p && (cyc % 256) == 0))
            tick(1);
    endtask

    task automatic step(input logic d);
        iDIR  = d;
        iSTEP = 1'b1;
        tick(4);
        iSTEP = 1'b0;
        tick(4);
    endtask

    // Write one byte with the gate open from byte clock 0, edges in cells 1
    // and 7; counts any read pulse seen while the gate is open.
    task automatic writeByte(output int rdSeen);
        rdSeen = 0;
        iWG = 1'b1;
        for (int b = 0; b < 256; b++) begin
            iWDATA = (b == 40 || b == 41 || b == 232 || b == 233);
            tick(1);
            if (oRDATA) rdSeen++;
        end
        iWDATA = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdHi, idxHi, riseA, riseB, rdW, c0, w0;
        logic idxPrev;

        iRESET = 1'b1; iMOTOR = 1'b0; iSTEP = 1'b0; iDIR = 1'b0; iSIDE1 = 1'b0;
        iWG = 1'b0; iWDATA = 1'b0; iIMG_READY = 1'b0; iIMG_WP = 1'b0; iDIRTY_CLR = 1'b0;
        tick(3);
        iRESET = 1'b0;
        tick(1);

        // Reset state
        chk("rst_addr",  oRAM_ADDR, 1);
        chk("rst_rdata", oRDATA,    0);
        chk("rst_index", oINDEX,    0);
        chk("rst_tr00",  oTR00,     1);
        chk("rst_track", oTRACK,    0);
        chk("rst_side",  oSIDE,     0);
        chk("rst_chg",   oTRK_CHG,  0);
        chk("rst_we",    oRAM_WE,   0);
        chk("rst_dirty", oDIRTY,    0);
        chk("rst_wprt",  oWPRT,     0);

        // Spin up: this cycle is clock 0 of byte 0
        iMOTOR = 1'b1; iIMG_READY = 1'b1;
        cyc = 0;
        #1;
        rdHi = 0; idxHi = 0; riseA = -1; riseB = -1; idxPrev = 1'b0;
        for (int c = 0; c < 8192; c++) begin
            if (c < 512 && oRDATA) rdHi++;
            if (c == 255) chk("rd_c255", oRDATA, 0);
            if (c == 256) chk("rd_c256", oRDATA, 1);
            if (c == 259) chk("rd_c259", oRDATA, 1);
            if (c == 260) chk("rd_c260", oRDATA, 0);
            if (c == 288) chk("rd_c288", oRDATA, 0);
            if (c == 320) chk("rd_c320", oRDATA, 1);
            if (c == 324) chk("rd_c324", oRDATA, 0);
            if (c < 4096 && oINDEX) idxHi++;
            if (oINDEX && !idxPrev) begin
                if (riseA < 0) riseA = c;
                else if (riseB < 0) riseB = c;
            end
            idxPrev = oINDEX;
            if (c == 3839) chk("addr_pos14", oRAM_ADDR, 15);
            if (c == 3841) chk("addr_wrap",  oRAM_ADDR, 0);
            tick(1);
        end
        chk("rd_count",   rdHi, 8);
        chk("idx_width",  idxHi, 512);
        chk("idx_rise",   riseA, 1);
        chk("idx_period", riseB - riseA, 4096);

        // Stepping
        c0 = chgCnt;
        step(1'b0);
        chk("stepout0_trk", oTRACK, 0);
        chk("stepout0_tr00", oTR00, 1);
        chk("stepout0_chg", chgCnt - c0, 0);

        c0 = chgCnt;
        iDIR = 1'b1; iSTEP = 1'b1;
        tick(2);
        chk("step_lat2", oTRACK, 0);
        tick(1);
        chk("step_lat3", oTRACK, 1);
        tick(1);
        iSTEP = 1'b0;
        tick(4);
        step(1'b1);
        step(1'b1);
        chk("step3_trk",  oTRACK, 3);
        chk("step3_tr00", oTR00,  0);
        chk("step3_chg",  chgCnt - c0, 3);

        c0 = chgCnt;
        repeat (90) step(1'b1);
        chk("step90_trk", oTRACK, 83);
        chk("step90_chg", chgCnt - c0, 80);
        c0 = chgCnt;
        step(1'b1);
        chk("stepsat_trk", oTRACK, 83);
        chk("stepsat_chg", chgCnt - c0, 0);

        // Step out together with a side change: one pulse
        c0 = chgCnt;
        iSIDE1 = 1'b1;
        step(1'b0);
        chk("side_trk",  oTRACK, 82);
        chk("side_side", oSIDE,  1);
        chk("side_chg",  chgCnt - c0, 1);

        // Write capture at pos 5
        gotoByte(5);
        w0 = weCnt;
        writeByte(rdW);
        chk("wr_we",    oRAM_WE,    1);
        chk("wr_addr",  oRAM_ADDR,  5);
        chk("wr_data",  oRAM_WDATA, 8'h41);
        iWG = 1'b0;
        tick(1);
        chk("wr_we_off", oRAM_WE,   0);
        chk("wr_addr2",  oRAM_ADDR, 7);
        chk("wr_dirty",  oDIRTY,    1);
        chk("wr_rdata",  rdW,       0);
        chk("wr_count",  weCnt - w0, 1);
        iDIRTY_CLR = 1'b1;
        tick(1);
        iDIRTY_CLR = 1'b0;
        chk("dirty_clr", oDIRTY, 0);

        // Write protect: capture runs, nothing written
        iIMG_WP = 1'b1;
        tick(1);
        chk("wp_wprt", oWPRT, 1);
        w0 = weCnt;
        gotoByte(5);
        writeByte(rdW);
        iWG = 1'b0;
        tick(2);
        chk("wp_nowrite", weCnt - w0, 0);
        chk("wp_dirty",   oDIRTY, 0);
        iIMG_WP = 1'b0;
        tick(1);

        // Gate dropped mid-byte: no write
        w0 = weCnt;
        gotoByte(8);
        iWG = 1'b1;
        tick(128);
        iWG = 1'b0;
        gotoByte(10);
        chk("wgfall_nowrite", weCnt - w0, 0);

        // Gate raised mid-byte 10, held through byte 11: only byte 11 written
        tick(128);
        iWG = 1'b1;
        gotoByte(12);
        chk("wgrise_we",   oRAM_WE,    1);
        chk("wgrise_addr", oRAM_ADDR,  11);
        chk("wgrise_data", oRAM_WDATA, 8'h00);
        iWG = 1'b0;
        tick(1);
        chk("wgrise_count", weCnt - w0, 1);

        // Motor off mid-pulse: everything freezes
        gotoByte(1);
        tick(1);
        chk("frz_pre_rd",  oRDATA, 1);
        chk("frz_pre_idx", oINDEX, 1);
        iMOTOR = 1'b0;
        #1;
        chk("frz_rd", oRDATA, 0);
        tick(1);
        chk("frz_idx", oINDEX, 0);
        tick(50);
        chk("frz_addr",  oRAM_ADDR, 2);
        chk("frz_rd2",   oRDATA,    0);
        chk("frz_idx2",  oINDEX,    0);

        // Reset in the middle of a capture
        iMOTOR = 1'b1;
        iWG = 1'b1;
        tick(100);
        w0 = weCnt;
        iRESET = 1'b1;
        tick(1);
        chk("rst2_addr",  oRAM_ADDR, 1);
        chk("rst2_rdata", oRDATA,    0);
        chk("rst2_index", oINDEX,    0);
        chk("rst2_tr00",  oTR00,     1);
        chk("rst2_track", oTRACK,    0);
        chk("rst2_side",  oSIDE,     0);
        chk("rst2_chg",   oTRK_CHG,  0);
        chk("rst2_we",    oRAM_WE,   0);
        chk("rst2_dirty", oDIRTY,    0);
        iRESET = 1'b0;
        tick(200);
        chk("rst2_abort", weCnt - w0, 0);
        chk("rst2_tr00b", oTR00, 1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fdd_track_emu.md
Name: fdd_track_emu

Overview:
- Floppy drive emulator that sits directly downstream of the FDC top level.
- Consumes the controller's drive-side outputs: STEP, DIR, SIDE1, MOTOR, WG, WR_DATA.
- Produces the drive-side inputs the controller reads: RDATA pulses, INDEX, TR00, WPRT.
- Track data comes from an external pre-MFM-encoded track RAM, which a host loader fills per track/side; written bitcells are captured back into that RAM.

Parameters:
CELL_CLKS, 32, clocks per MFM bitcell (16 MHz, 2 us cell, 250 kbit/s)
TRACK_BYTES, 12500, raw MFM bytes per track (8 cells each, MSB first)
INDEX_BYTES, 250, raw bytes from position 0 during which oINDEX is high (~4 ms)
PULSE_CLKS, 4, width of an oRDATA pulse in clocks
MAX_TRACK, 83, highest reachable cylinder

Ports:
iCLK  in  1  clock, the FDC 16 MHz clock
iRESET  in  1  synchronous active-high reset
iMOTOR  in  1  spindle enable
iSTEP  in  1  step strobe, asynchronous, rising edge active
iDIR  in  1  1 = step in (track+1), 0 = step out
iSIDE1  in  1  1 = side 1 selected
iWG  in  1  write gate
iWDATA  in  1  write pulses, asynchronous
iIMG_READY  in  1  track RAM holds a valid image
iIMG_WP  in  1  image write protect
iRAM_DATA  in  8  track RAM read data; 1-cycle latency after oRAM_ADDR
oRAM_ADDR  out  14  track RAM byte address
oRAM_WDATA  out  8  captured raw byte
oRAM_WE  out  1  one-clock write strobe
oRDATA  out  1  read pulse, active high
oINDEX  out  1  index, active high
oTR00  out  1  head at cylinder 0
oWPRT  out  1  equals iIMG_WP, registered
oTRACK  out  7  current cylinder
oSIDE  out  1  registered iSIDE1
oTRK_CHG  out  1  one-clock pulse when cylinder or side changes
oDIRTY  out  1  set by any RAM write
iDIRTY_CLR  in  1  clears oDIRTY

Behaviour:
- Reset values: track=0, pos=0, cell_cnt=0, cell_idx=0, shift=0. Outputs: oRAM_ADDR=1, oRDATA=0, oINDEX=0, oTR00=1, oWPRT=0, oTRACK=0, oSIDE=0, oTRK_CHG=0, oRAM_WE=0, oDIRTY=0. Reset mid-operation aborts any partial capture byte with no write.
- Spinning = iMOTOR & iIMG_READY. When not spinning: counters freeze, oRDATA=0, oINDEX=0, capture buffer cleared.
- Rotation counters:
  - cell_cnt counts 0..CELL_CLKS-1.
  - At wrap, cell_idx increments 0..7.
  - At cell_idx wrap, pos increments 0..TRACK_BYTES-1, wrapping to 0.
  - One byte = 8*CELL_CLKS clocks.
- Read path:
  - From clock 1 of each byte, oRAM_ADDR = (pos+1) mod TRACK_BYTES.
  - On the final clock of the byte (cell_idx=7, cell_cnt=CELL_CLKS-1), shift <= iRAM_DATA.
  - At cell_cnt=0 of each cell: if the current shift bit (MSB first) is 1 and iWG=0, oRDATA goes high for exactly PULSE_CLKS clocks.
  - oRDATA is forced 0 while iWG=1.
- Index: oINDEX = spinning & (pos < INDEX_BYTES), registered.
- Step:
  - iSTEP passes a 2-FF synchroniser, then rising-edge detect; the track updates 3 clocks after the raw edge.
  - DIR=1: track = min(track+1, MAX_TRACK). DIR=0: track = max(track-1, 0).
  - Steps are honoured even when not spinning.
  - oTR00 = (track==0).
  - oTRK_CHG pulses one clock when track actually changes; a saturated step produces no pulse.
- Side: iSIDE1 is synchronised to oSIDE; a change pulses oTRK_CHG. A simultaneous step and side change produce a single pulse.
- Write capture:
  - iWDATA passes a 2-FF synchroniser and rising-edge detect.
  - While iWG=1 and spinning, a cell containing at least one edge records 1, else 0; bits shift MSB first.
  - After cell 7 the byte is complete. On clock 0 of the next byte: oRAM_WE=1, oRAM_ADDR=previous pos, oRAM_WDATA=byte. oRAM_ADDR returns to pos+1 on clock 1.
  - Only bytes whose whole 8 cells were spent with iWG=1 are written. A partial byte at WG rise or fall is discarded.
  - iIMG_WP=1 suppresses oRAM_WE; capture still runs.
  - Any write sets oDIRTY. iDIRTY_CLR clears it; a write in the same clock wins.
  - A write on the wrap from pos=TRACK_BYTES-1 targets address TRACK_BYTES-1.
- The track RAM is not reloaded by this block; after oTRK_CHG, data is whatever the loader provides. Settling is the controller's responsibility.

Test Plan:
1. Reset, then iMOTOR=1, iIMG_READY=1, TRACK_BYTES=16, RAM byte1=8'hA0 -> during byte 1, oRDATA pulses 4 clocks wide starting at cell_cnt=0 of cells 0 and 2 (byte-relative clocks 0 and 64), no other pulses.
2. Run two revolutions with INDEX_BYTES=2 -> oINDEX high for exactly 512 clocks per revolution, period 4096 clocks; oRAM_ADDR wraps 15->0.
3. From track 0: one step with DIR=0 -> no change, oTR00=1, no oTRK_CHG. Then 3 steps with DIR=1 -> oTRACK=3, oTR00=0, three oTRK_CHG pulses. 90 steps in -> oTRACK=83.
4. Assert iWG at byte boundary pos=5 and drive an edge in cells 1 and 7 for one byte -> oRAM_WE one clock with oRAM_ADDR=5, oRAM_WDATA=8'h41, oDIRTY=1, oRDATA=0 throughout.
5. Repeat scenario 4 with iIMG_WP=1 -> no oRAM_WE, oDIRTY stays 0, oWPRT=1. Drop iWG mid-byte -> no write.
6. Deassert iMOTOR mid-byte, then assert iRESET mid-capture -> counters freeze, oRDATA/oINDEX=0; after reset, all outputs at reset values, oTR00=1.
